// File: rtl/ledcube_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ledcube_pkg
// Brief    : Shared constants, FSM state type and lane helper for the
//            LED-cube frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
package ledcube_pkg;

    // Swap policy selectors for pingpong_fb SWAP_MODE
    localparam int SWAP_AT_FRAME_END = 0;
    localparam int SWAP_IMMEDIATE    = 1;

    // Swap-control FSM state
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } fb_state_t;

    // Number of byte-enable lanes covering one data word
    function automatic int lanes_of(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_be
// Brief    : Single-clock simple dual-port RAM with per-lane write enables
//            and a registered read port. Array contents are not reset; only
//            the read output register is.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram_be
    import ledcube_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int LANE_WIDTH = 8,
    parameter int LANES      = lanes_of(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [LANES-1:0]      wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Lane-masked write: disabled lanes keep their previous contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Registered read; data holds when idle, valid flags only real reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_mem[rd_addr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: rtl/pingpong_fb.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_fb
// Brief    : Double-buffered LED-cube frame buffer. Writes fill the back bank,
//            reads scan the front bank, and the banks exchange only on a
//            tear-free boundary under a request/pending/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_fb
    import ledcube_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int LANE_WIDTH = 8,
    parameter int SWAP_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
    input  logic                             swap_req,
    output logic                             swap_pending,
    output logic                             swap_done,
    output logic                             front_bank,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic                             rd_frame_end,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int LANES = lanes_of(DATA_WIDTH, LANE_WIDTH);

    fb_state_t r_state;
    logic      r_front_bank;
    logic      r_swap_pending;
    logic      r_swap_done;

    logic      w_wr_fire;
    logic      w_swap_now;

    // Writes stall (never drop) while an exchange is outstanding
    assign w_wr_fire  = wr_valid & ~r_swap_pending;

    // Exchange point: immediately in PENDING, or at the next scan frame end
    assign w_swap_now = (r_state == PENDING) &&
                        ((SWAP_MODE == SWAP_IMMEDIATE) || rd_frame_end);

    // Swap-control FSM with registered bank pointer and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_front_bank   <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A frame end coinciding with the request does not swap
                    if (swap_req) begin
                        r_state        <= PENDING;
                        r_swap_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    // Further requests here are ignored, not queued
                    if (w_swap_now) begin
                        r_state        <= IDLE;
                        r_swap_pending <= 1'b0;
                        r_front_bank   <= ~r_front_bank;
                        r_swap_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_swap_pending <= 1'b0;
                end
            endcase
        end
    end

    // Bank bit is the RAM address MSB; reads in the swap cycle see the old front
    sdp_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1),
        .LANE_WIDTH (LANE_WIDTH),
        .LANES      (LANES)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_wr_fire),
        .wr_addr  ({~r_front_bank, wr_addr}),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  ({r_front_bank, rd_addr}),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    assign wr_ready     = ~r_swap_pending;
    assign swap_pending = r_swap_pending;
    assign swap_done    = r_swap_done;
    assign front_bank   = r_front_bank;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_fb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_fb
// Brief    : Directed self-checking bench for pingpong_fb, one instance per
//            swap mode; read data checked against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_fb;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int LW = 8;
    localparam int LN = DW / LW;

    logic          clk = 1'b0;
    logic          rst;

    // Mode-0 (frame-end swap) instance signals
    logic          wv, wr_rdy, sr, pend, done, front, re, fe, rv;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd;
    logic [LN-1:0] wbe;

    // Mode-1 (immediate swap) instance signals
    logic          wv1, wr_rdy1, sr1, pend1, done1, front1, re1, fe1, rv1;
    logic [AW-1:0] wa1, ra1;
    logic [DW-1:0] wd1, rd1;
    logic [LN-1:0] wbe1;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb [$];

    always #5 clk = ~clk;

    pingpong_fb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .SWAP_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .wr_valid(wv), .wr_ready(wr_rdy), .wr_addr(wa), .wr_data(wd), .wr_be(wbe),
        .swap_req(sr), .swap_pending(pend), .swap_done(done), .front_bank(front),
        .rd_en(re), .rd_addr(ra), .rd_frame_end(fe), .rd_data(rd), .rd_valid(rv)
    );

    pingpong_fb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .SWAP_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .wr_valid(wv1), .wr_ready(wr_rdy1), .wr_addr(wa1), .wr_data(wd1), .wr_be(wbe1),
        .swap_req(sr1), .swap_pending(pend1), .swap_done(done1), .front_bank(front1),
        .rd_en(re1), .rd_addr(ra1), .rd_frame_end(fe1), .rd_data(rd1), .rd_valid(rv1)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] be);
        check("wr_ready_at_write", {63'd0, wr_rdy}, 64'd1);
        wv = 1'b1; wa = a; wd = d; wbe = be;
        tick();
        wv = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        re = 1'b1; ra = a;
        sb.push_back(exp);
        tick();
        re = 1'b0;
    endtask

    // Scoreboard: every returned read pops one expected word
    always @(negedge clk) begin
        if (rv) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL rd_unexpected observed=%h expected=no_read", rd);
            end else begin
                check("rd_data", rd, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        wv = 1'b0; wa = '0; wd = '0; wbe = '0; sr = 1'b0; re = 1'b0; ra = '0; fe = 1'b0;
        wv1 = 1'b0; wa1 = '0; wd1 = '0; wbe1 = '0; sr1 = 1'b0; re1 = 1'b0; ra1 = '0; fe1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_front",   {63'd0, front},  64'd0);
        check("rst_pending", {63'd0, pend},   64'd0);
        check("rst_done",    {63'd0, done},   64'd0);
        check("rst_rd_valid",{63'd0, rv},     64'd0);
        check("rst_rd_data", rd,              64'd0);
        check("rst_wr_ready",{63'd0, wr_rdy}, 64'd1);

        // Mode 1: swap_done two cycles after the request, frame end unused
        sr1 = 1'b1;
        tick();
        sr1 = 1'b0;
        check("m1_pending_rise", {63'd0, pend1},   64'd1);
        check("m1_wr_ready_low", {63'd0, wr_rdy1}, 64'd0);
        check("m1_done_early",   {63'd0, done1},   64'd0);
        check("m1_front_early",  {63'd0, front1},  64'd0);
        tick();
        check("m1_done",         {63'd0, done1},   64'd1);
        check("m1_front",        {63'd0, front1},  64'd1);
        check("m1_pending_fall", {63'd0, pend1},   64'd0);
        check("m1_wr_ready_back",{63'd0, wr_rdy1}, 64'd1);
        tick();
        check("m1_done_pulse",   {63'd0, done1},   64'd0);
        check("m1_front_hold",   {63'd0, front1},  64'd1);

        // Bank isolation and lane mask: fill bank 1 while bank 0 is front
        do_write(8'd5, {8{8'h11}}, 8'hFF);
        do_write(8'd7, {64{1'b1}}, 8'hFF);
        do_write(8'd7, 64'd0,      8'h0F);
        sr = 1'b1;
        tick();
        sr = 1'b0;
        check("a_pending",  {63'd0, pend},   64'd1);
        check("a_wr_ready", {63'd0, wr_rdy}, 64'd0);
        check("a_front",    {63'd0, front},  64'd0);
        tick(); tick();
        check("a_still_pending", {63'd0, pend}, 64'd1);
        check("a_no_done",       {63'd0, done}, 64'd0);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check("a_swap_done",  {63'd0, done},   64'd1);
        check("a_swap_front", {63'd0, front},  64'd1);
        check("a_pend_fall",  {63'd0, pend},   64'd0);
        check("a_ready_back", {63'd0, wr_rdy}, 64'd1);
        tick();
        check("a_done_pulse", {63'd0, done},   64'd0);
        do_read(8'd5, {8{8'h11}});
        do_read(8'd7, 64'hFFFF_FFFF_0000_0000);
        tick();
        check("a_rd_valid_idle", {63'd0, rv}, 64'd0);
        check("a_rd_data_hold",  rd, 64'hFFFF_FFFF_0000_0000);

        // Stall: bank 0 is back; held write must wait out the pending window
        do_write(8'd5, {8{8'h22}}, 8'hFF);
        do_write(8'd9, {8{8'h55}}, 8'hFF);
        sr = 1'b1;
        tick();
        sr = 1'b0;
        wv = 1'b1; wa = 8'd9; wd = {8{8'hAA}}; wbe = 8'hFF;
        check("b_wr_ready_low", {63'd0, wr_rdy}, 64'd0);
        sr = 1'b1;
        tick();
        sr = 1'b0;
        check("b_pending_after_rereq", {63'd0, pend}, 64'd1);
        tick();
        check("b_wr_ready_still_low", {63'd0, wr_rdy}, 64'd0);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check("b_swap_front", {63'd0, front},  64'd0);
        check("b_swap_done",  {63'd0, done},   64'd1);
        check("b_ready_back", {63'd0, wr_rdy}, 64'd1);
        tick();
        wv = 1'b0;
        check("b_done_pulse", {63'd0, done}, 64'd0);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check("b_single_toggle", {63'd0, front}, 64'd0);
        check("b_no_pending",    {63'd0, pend},  64'd0);
        check("b_no_second_done",{63'd0, done},  64'd0);
        do_read(8'd9, {8{8'h55}});
        do_read(8'd5, {8{8'h22}});
        tick();

        // Boundary: request with frame end does not swap; read on swap cycle is old bank
        sr = 1'b1; fe = 1'b1;
        tick();
        sr = 1'b0; fe = 1'b0;
        check("c_pending",   {63'd0, pend},  64'd1);
        check("c_no_swap",   {63'd0, front}, 64'd0);
        check("c_no_done",   {63'd0, done},  64'd0);
        tick();
        check("c_still_front0", {63'd0, front}, 64'd0);
        fe = 1'b1;
        do_read(8'd5, {8{8'h22}});
        fe = 1'b0;
        check("c_swap_front", {63'd0, front}, 64'd1);
        check("c_swap_done",  {63'd0, done},  64'd1);
        do_read(8'd9, {8{8'hAA}});
        do_read(8'd5, {8{8'h11}});
        tick();

        // Reset while pending: request dropped, bank forced to 0, read discarded
        sr = 1'b1;
        tick();
        sr = 1'b0;
        check("d_pending", {63'd0, pend}, 64'd1);
        rst = 1'b1; re = 1'b1; ra = 8'd5;
        tick();
        rst = 1'b0; re = 1'b0;
        check("d_front",    {63'd0, front}, 64'd0);
        check("d_pending0", {63'd0, pend},  64'd0);
        check("d_rd_valid", {63'd0, rv},    64'd0);
        check("d_no_done",  {63'd0, done},  64'd0);
        tick();
        check("d_no_late_done",  {63'd0, done},  64'd0);
        check("d_front_stays",   {63'd0, front}, 64'd0);
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pingpong_fb.md
# pingpong_fb

Double-buffered LED-cube frame buffer. A write side fills the back bank while a read side scans the front bank. The banks exchange only on a tear-free boundary. It sits between the pattern/frame generator (write side) and the panel scan driver (read side). It is the successor to the team's plain two-port BRAM: single clock, byte-lane write enables, and a managed bank swap with handshake.

## Interface
- DATA_WIDTH, 64, bits per word; must be a multiple of LANE_WIDTH
- ADDR_WIDTH, 8, word address width per bank; each bank holds 2**ADDR_WIDTH words
- LANE_WIDTH, 8, bits per write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH
- SWAP_MODE, 0, 0 = swap at read frame end; 1 = swap on the cycle after the request
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_WIDTH  back-bank word address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  LANES  lane enables; lane i covers bits [i*LANE_WIDTH +: LANE_WIDTH]
- swap_req  in  1  single-cycle pulse: back bank complete, request exchange
- swap_pending  out  1  request accepted, exchange not yet done
- swap_done  out  1  one-cycle pulse on the cycle front_bank changes
- front_bank  out  1  index of the bank currently read
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  front-bank word address
- rd_frame_end  in  1  marks the final read of a scan frame; valid with or without rd_en
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data updated this cycle

## Operation
- **Storage:** 2 banks × 2**ADDR_WIDTH words. The physical address is {bank, addr}. Writes always target the bank !front_bank; reads always target front_bank. No read-during-write hazard exists between the sides.
- **Writes:**
  - Lanes with wr_be=0 keep their old contents.
  - wr_be=0 entirely makes the write a no-op, but the write is still accepted.
  - wr_ready = !swap_pending. Writes offered while pending are stalled, never dropped.
- **FSM, 2 states:**
  - IDLE → PENDING on swap_req.
  - PENDING → IDLE with the swap when the condition below holds.
- **Swap condition:**
  - SWAP_MODE 0: swap on the first cycle in PENDING where rd_frame_end=1.
  - SWAP_MODE 1: swap on the first cycle in PENDING, i.e. the cycle after the request.
- **Swap action:**
  - front_bank toggles.
  - swap_done pulses on the same edge the toggle becomes visible.
  - swap_pending falls on that same edge.
- **Request edge cases:**
  - swap_req while PENDING: ignored, not queued.
  - swap_req together with rd_frame_end while IDLE: the request only enters PENDING; the swap waits for the next frame end (mode 0).
- **Reads:** reads issued in the swap cycle, including the rd_frame_end read, use the old front bank.
- **Memory contents:** not reset; initial contents undefined. The bench must write before it reads.

## Timing
- **Reset values:** front_bank=0, swap_pending=0, swap_done=0, rd_valid=0, rd_data=0, FSM=IDLE. wr_ready=1 from the first cycle after reset.
- **Read latency:** rd_en at edge N gives rd_data and rd_valid=1 after edge N+1. rd_data holds its value while rd_en=0. rd_valid=0 in cycles without a read.
- **Write latency:** a write accepted at edge N is visible to a read of that bank issued at N+1 or later, after a swap.
- **swap_pending:** rises the cycle after swap_req.
  - Mode 1: swap_done occurs 2 cycles after swap_req, and wr_ready is low for exactly 1 cycle.
  - Mode 0: wr_ready stays low from the cycle after swap_req through the cycle of the swap edge.
- **Reset mid-operation:** rst in PENDING drops the request, returns to IDLE and forces front_bank to 0. Reads in flight are discarded (rd_valid=0 next cycle).

## Structure
- **Shared package** (`ledcube_pkg`):
  - SWAP_AT_FRAME_END=0 and SWAP_IMMEDIATE=1 constants.
  - The FSM state typedef (IDLE, PENDING).
  - The LANES derivation function.
- **Sub-module** `sdp_ram_be`: single-clock simple dual-port RAM with per-lane write enables and a registered read port. It is instantiated once with ADDR_WIDTH+1 address bits; the bank bit is the MSB.
- **Top level:** FSM, bank pointer, ready/valid logic.

## Test plan
- **Bank isolation:** reset, write 0x1111… to addr 5, swap (mode 0, frame_end 3 cycles after the request), read addr 5 → 0x1111… one cycle after rd_en; front_bank=1; swap_done is a single pulse.
- **Lane mask:** write 0xFFFF_FFFF_FFFF_FFFF to addr 7, then write 0 with wr_be=8'h0F to the same address, swap, read → 0xFFFF_FFFF_0000_0000.
- **Stall:** hold wr_valid during PENDING → wr_ready=0 and no write lands until the cycle after swap_done; swap_req repeated while pending → exactly one toggle.
- **Boundary:** swap_req and rd_frame_end in the same cycle → no swap; the next frame_end swaps; a read on the swap cycle returns old-bank data.
- **Mode 1:** SWAP_MODE=1, swap_req at cycle 10 → swap_done at cycle 12, front_bank toggles, rd_frame_end ignored.
- **Reset mid-pending:** swap_req, then rst one cycle later → front_bank=0, swap_pending=0, rd_valid=0, no swap_done.
